// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-requester round-robin/locking arbiter for a shared dual-address RAM
module ram_port_arbiter #(
  parameter int BIT_WIDTH  = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int RD_LAT     = 2,
  parameter int MAX_LOCK   = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  wr0,
  input  logic                  wr1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [BIT_WIDTH-1:0]  wdata0,
  input  logic [BIT_WIDTH-1:0]  wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [BIT_WIDTH-1:0]  rdata,
  output logic [ADDR_WIDTH-1:0] ram_rdaddr,
  output logic [ADDR_WIDTH-1:0] ram_wraddr,
  output logic [BIT_WIDTH-1:0]  ram_data,
  output logic                  ram_wren,
  input  logic [BIT_WIDTH-1:0]  ram_q,
  output logic [1:0]            owner
);
  localparam int CW = $clog2(MAX_LOCK + 1);
  typedef enum logic [1:0] {ARB = 2'b00, LOCK0 = 2'b01, LOCK1 = 2'b10} state_t;
  state_t state, state_d;
  logic ptr, ptr_d, any, win, wr, lk, hold, rd;
  logic [CW-1:0] cnt, cnt_d, cnt_inc;
  logic [ADDR_WIDTH-1:0] addr;
  logic [BIT_WIDTH-1:0] wd;
  logic [RD_LAT-1:0] vld, tag;
  always_comb begin
    gnt0 = reset & (state == ARB ? req0 & (~req1 | ptr) : state == LOCK0 & req0);
    gnt1 = reset & (state == ARB ? req1 & (~req0 | ~ptr) : state == LOCK1 & req1);
    any = gnt0 | gnt1;
    win = gnt1;
    wr = win ? wr1 : wr0;
    lk = win ? lock1 : lock0;
    addr = win ? addr1 : addr0;
    wd = win ? wdata1 : wdata0;
    rd = any & ~wr;
    ram_wren = any & wr;
    ram_wraddr = ram_wren ? addr : '0;
    ram_data = ram_wren ? wd : '0;
    ram_rdaddr = rd ? addr : '0;
    rdata = ram_q;
    rvalid0 = vld[RD_LAT-1] & ~tag[RD_LAT-1];
    rvalid1 = vld[RD_LAT-1] & tag[RD_LAT-1];
    hold = state == LOCK1 ? lock1 : lock0;
    cnt_inc = cnt + 1'b1;
    ptr_d = any ? win : ptr;
    state_d = state;
    cnt_d = cnt;
    if (state == ARB) begin
      if (any & lk) begin
        state_d = win ? LOCK1 : LOCK0;
        cnt_d = CW'(1);
      end
    end else if (!hold || (any && cnt_inc == CW'(MAX_LOCK))) begin
      state_d = ARB;
      cnt_d = '0;
    end else if (any) begin
      cnt_d = cnt_inc;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ARB;
      ptr <= 1'b1;
      cnt <= '0;
      vld <= '0;
      tag <= '0;
      owner <= 2'b00;
    end else begin
      state <= state_d;
      ptr <= ptr_d;
      cnt <= cnt_d;
      vld <= (vld << 1) | RD_LAT'(rd);
      tag <= (tag << 1) | RD_LAT'(rd & win);
      owner <= state_d;
    end
  end
endmodule
